generador_enemigos: RTL and testbench

//  Enemy sequencer for the hero game. Spawns the standard enemy glyphs (upper set 0-2, lower set 3-6)
//  at the far digit of an N-digit 7-segment row and scrolls them one digit per step toward the hero
//  in digit 0. It also detects collisions with the hero glyph and counts dodged enemies.

---
 rtl/generador_enemigos.sv | 163 ++++++++++++++++
 tb/tb_generador_enemigos.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/generador_enemigos.sv
// Enemy sequencer: spawns glyphs at the far digit, scrolls them toward the hero, flags collisions, counts dodges.
// Optional macro VELOCIDAD_AUTO_EN: effective speed level rises by one every 8 dodged enemies (capped at 3).
module generador_enemigos #(
  parameter int         N_DIGITS  = 4,
  parameter int         TICK_DIV  = 25000000,
  parameter int         GAP_MIN   = 1,
  parameter logic [7:0] LFSR_SEED = 8'hA5,
  parameter int         SCORE_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  pausa,
  input  logic [1:0]            nivel,
  input  logic [6:0]            heroe,
  output logic [7*N_DIGITS-1:0] enemigos,
  output logic                  choque,
  output logic [SCORE_W-1:0]    puntos,
  output logic                  activo
);

  localparam int EW    = 7 * N_DIGITS;
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GAP_W = (GAP_MIN > 0) ? $clog2(GAP_MIN + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_SAT    = GAP_W'(GAP_MIN);
  localparam logic [31:0]      TICK_DIV_U = TICK_DIV;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HIT} state_t;

  state_t             state_q, state_d;
  logic [EW-1:0]      enemigos_q, enemigos_d;
  logic [SCORE_W-1:0] puntos_q, puntos_d;
  logic [7:0]         lfsr_q, lfsr_d;
  logic [CNT_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;

  logic        hit;
  logic        reiniciar;
  logic        avanza;
  logic        paso;
  logic        spawn_ok;
  logic        lfsr_fb;
  logic [1:0]  nivel_ef;
  logic [31:0] periodo;
  logic [EW-1:0] desplazado;

  function automatic logic [6:0] glifo(input logic [2:0] idx);
    logic [6:0] g;
    case (idx)
      3'd0:    g = 7'b1100000;
      3'd1:    g = 7'b1000010;
      3'd2:    g = 7'b1100011;
      3'd3:    g = 7'b0011110;
      3'd4:    g = 7'b0001100;
      3'd5:    g = 7'b0011000;
      3'd6:    g = 7'b0011100;
      default: g = 7'b0000000;
    endcase
    return g;
  endfunction

`ifdef VELOCIDAD_AUTO_EN
  localparam int SUM_W = SCORE_W + 1;
  logic [SUM_W-1:0] nivel_sum;
  always_comb begin
    nivel_sum = SUM_W'(nivel) + SUM_W'(puntos_q >> 3);
    nivel_ef  = (nivel_sum > SUM_W'(3)) ? 2'd3 : nivel_sum[1:0];
  end
`else
  assign nivel_ef = nivel;
`endif

  always_comb begin
    periodo = TICK_DIV_U >> nivel_ef;
    if (periodo == 32'd0) begin
      periodo = 32'd1;
    end
  end

  // Collision is evaluated on the registered hero-side digit, even while paused.
  assign hit       = (state_q == S_RUN) && ((enemigos_q[6:0] & heroe) != 7'd0);
  assign reiniciar = start && (state_q != S_RUN);
  assign avanza    = (state_q == S_RUN) && !hit && !pausa;
  // >= keeps the counter from running past a period that shrank mid-count.
  assign paso      = avanza && (32'(tick_cnt_q) >= (periodo - 32'd1));
  assign spawn_ok  = lfsr_q[3] && (lfsr_q[2:0] != 3'd7) && (gap_cnt_q >= GAP_SAT);
  assign lfsr_fb   = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

  genvar gi;
  generate
    for (gi = 0; gi < N_DIGITS - 1; gi++) begin : g_shift
      assign desplazado[7*gi +: 7] = enemigos_q[7*(gi+1) +: 7];
    end
  endgenerate
  assign desplazado[EW-1 -: 7] = spawn_ok ? glifo(lfsr_q[2:0]) : 7'd0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      enemigos_q <= '0;
      puntos_q   <= '0;
      lfsr_q     <= LFSR_SEED;
      tick_cnt_q <= '0;
      gap_cnt_q  <= GAP_SAT;
    end else begin
      state_q    <= state_d;
      enemigos_q <= enemigos_d;
      puntos_q   <= puntos_d;
      lfsr_q     <= lfsr_d;
      tick_cnt_q <= tick_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (hit)   state_d = S_HIT;
      S_HIT:   if (start) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    enemigos_d = enemigos_q;
    puntos_d   = puntos_q;
    lfsr_d     = lfsr_q;
    tick_cnt_d = tick_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    if (reiniciar) begin
      enemigos_d = '0;
      puntos_d   = '0;
      lfsr_d     = LFSR_SEED;
      tick_cnt_d = '0;
      gap_cnt_d  = GAP_SAT;
    end else if (avanza) begin
      lfsr_d = {lfsr_q[6:0], lfsr_fb};
      if (paso) begin
        tick_cnt_d = '0;
        enemigos_d = desplazado;
        if (spawn_ok) begin
          gap_cnt_d = '0;
        end else if (gap_cnt_q < GAP_SAT) begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
        if ((enemigos_q[6:0] != 7'd0) && (puntos_q != '1)) begin
          puntos_d = puntos_q + SCORE_W'(1);
        end
      end else begin
        tick_cnt_d = tick_cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    activo   = (state_q == S_RUN);
    choque   = (state_q == S_HIT);
    enemigos = enemigos_q;
    puntos   = puntos_q;
  end

endmodule

// File: tb/tb_generador_enemigos.sv
// Self-checking bench for generador_enemigos: vector table plus collision/restart sequences against a cycle model.
module tb_generador_enemigos;

  localparam int ND = 4;
  localparam int TD = 8;
  localparam int GM = 1;
  localparam logic [7:0] SEED = 8'hA5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        pausa = 1'b0;
  logic [1:0]  nivel = 2'd0;
  logic [6:0]  heroe = 7'd0;
  logic [27:0] enemigos;
  logic        choque;
  logic [7:0]  puntos;
  logic        activo;

  int n_checks = 0;
  int n_errors = 0;

  generador_enemigos #(
    .N_DIGITS(ND), .TICK_DIV(TD), .GAP_MIN(GM), .LFSR_SEED(SEED), .SCORE_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pausa(pausa), .nivel(nivel),
    .heroe(heroe), .enemigos(enemigos), .choque(choque), .puntos(puntos), .activo(activo)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [27:0] en;
    logic        ch;
    logic [7:0]  pts;
    logic        act;
  } exp_t;

  exp_t sb_q[$];

  // Reference model state: 0 idle, 1 run, 2 hit
  int         m_state = 0;
  logic [6:0] m_dig [ND];
  logic [7:0] m_pts  = 8'd0;
  logic [7:0] m_lfsr = SEED;
  int         m_tick = 0;
  int         m_gap  = GM;

  function automatic logic [6:0] tb_glyph(input logic [2:0] idx);
    logic [6:0] tbl [7];
    tbl = '{7'b1100000, 7'b1000010, 7'b1100011, 7'b0011110, 7'b0001100, 7'b0011000, 7'b0011100};
    return (idx == 3'd7) ? 7'd0 : tbl[idx];
  endfunction

  function automatic bit is_glyph(input logic [6:0] g);
    bit ok;
    ok = (g == 7'd0);
    for (int k = 0; k < 7; k++) if (g == tb_glyph(3'(k))) ok = 1'b1;
    return ok;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int d = 0; d < ND; d++) m_dig[d] = 7'd0;
    m_pts  = 8'd0;
    m_lfsr = SEED;
    m_tick = 0;
    m_gap  = GM;
  endtask

  task automatic model_cycle();
    int lvl;
    int per;
    logic fb;
    if (!rst_n) begin
      m_state = 0;
      model_clear();
    end else if (m_state != 1) begin
      if (start) begin
        m_state = 1;
        model_clear();
      end
    end else if ((m_dig[0] & heroe) != 7'd0) begin
      m_state = 2;
    end else if (!pausa) begin
      lvl = int'(nivel);
`ifdef VELOCIDAD_AUTO_EN
      lvl = lvl + int'(m_pts >> 3);
      if (lvl > 3) lvl = 3;
`endif
      per = TD >> lvl;
      if (per < 1) per = 1;
      if (m_tick >= per - 1) begin
        m_tick = 0;
        if (m_dig[0] != 7'd0 && m_pts != 8'hFF) m_pts = m_pts + 8'd1;
        for (int d = 0; d < ND - 1; d++) m_dig[d] = m_dig[d+1];
        if (m_lfsr[3] && m_lfsr[2:0] != 3'd7 && m_gap >= GM) begin
          m_dig[ND-1] = tb_glyph(m_lfsr[2:0]);
          m_gap = 0;
        end else begin
          m_dig[ND-1] = 7'd0;
          if (m_gap < GM) m_gap++;
        end
      end else begin
        m_tick++;
      end
      fb = m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3];
      m_lfsr = {m_lfsr[6:0], fb};
    end
  endtask

  task automatic ciclo(input logic r, input logic s, input logic p, input logic [1:0] nv, input logic [6:0] h);
    exp_t e;
    bit legal;
    bit adj;
    logic [6:0] g;
    @(negedge clk);
    rst_n = r; start = s; pausa = p; nivel = nv; heroe = h;
    model_cycle();
    e.en  = {m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
    e.ch  = (m_state == 2);
    e.pts = m_pts;
    e.act = (m_state == 1);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check("enemigos", 32'(enemigos), 32'(e.en));
      check("choque", 32'(choque), 32'(e.ch));
      check("puntos", 32'(puntos), 32'(e.pts));
      check("activo", 32'(activo), 32'(e.act));
    end
    legal = 1'b1;
    adj   = 1'b0;
    for (int d = 0; d < ND; d++) begin
      g = enemigos[7*d +: 7];
      if (!is_glyph(g)) legal = 1'b0;
      if (d < ND - 1 && g != 7'd0 && enemigos[7*(d+1) +: 7] != 7'd0) adj = 1'b1;
    end
    check("glyph_legal", 32'(legal), 32'd1);
    check("no_adjacent", 32'(adj), 32'd0);
  endtask

  task automatic check_const(input string nm, input logic [27:0] en, input logic ch, input logic [7:0] pts, input logic act);
    check({nm, "_en"}, 32'(enemigos), 32'(en));
    check({nm, "_choque"}, 32'(choque), 32'(ch));
    check({nm, "_puntos"}, 32'(puntos), 32'(pts));
    check({nm, "_activo"}, 32'(activo), 32'(act));
  endtask

  typedef struct {
    logic       r;
    logic       s;
    logic       p;
    logic [1:0] nv;
    logic [6:0] h;
    int         cycles;
    bit         chk;
    logic       x_act;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic s, input logic p, input logic [1:0] nv,
                              input logic [6:0] h, input int cycles, input bit chk, input logic x_act);
    vec_t v;
    v.r = r; v.s = s; v.p = p; v.nv = nv; v.h = h; v.cycles = cycles; v.chk = chk; v.x_act = x_act;
    return v;
  endfunction

  localparam int NV = 16;
  vec_t vecs [NV];

  initial begin
    bit hit_seen;
    // chk=1 rows expect enemigos=0, choque=0, puntos=0 and activo=x_act at the end of the row
    vecs[0]  = mk(1'b0, 1'b0, 1'b0, 2'd0, 7'd0,    3, 1'b1, 1'b0);
    vecs[1]  = mk(1'b1, 1'b0, 1'b1, 2'd0, 7'd0,    5, 1'b1, 1'b0);
    vecs[2]  = mk(1'b1, 1'b1, 1'b0, 2'd0, 7'd0,    1, 1'b1, 1'b1);
    vecs[3]  = mk(1'b1, 1'b0, 1'b0, 2'd0, 7'd0, 1600, 1'b0, 1'b1);
    vecs[4]  = mk(1'b1, 1'b1, 1'b0, 2'd0, 7'd0,    1, 1'b0, 1'b1);
    vecs[5]  = mk(1'b0, 1'b1, 1'b0, 2'd0, 7'd0,    1, 1'b1, 1'b0);
    vecs[6]  = mk(1'b1, 1'b1, 1'b0, 2'd3, 7'd0,    1, 1'b1, 1'b1);
    vecs[7]  = mk(1'b1, 1'b0, 1'b0, 2'd3, 7'd0,   60, 1'b0, 1'b1);
    vecs[8]  = mk(1'b1, 1'b0, 1'b1, 2'd3, 7'd0,   20, 1'b0, 1'b1);
    vecs[9]  = mk(1'b1, 1'b0, 1'b0, 2'd3, 7'd0,   40, 1'b0, 1'b1);
    vecs[10] = mk(1'b0, 1'b0, 1'b0, 2'd3, 7'd0,    1, 1'b1, 1'b0);
    vecs[11] = mk(1'b1, 1'b1, 1'b0, 2'd2, 7'd0,    1, 1'b1, 1'b1);
    vecs[12] = mk(1'b1, 1'b0, 1'b0, 2'd2, 7'd0,   80, 1'b0, 1'b1);
    vecs[13] = mk(1'b1, 1'b0, 1'b1, 2'd2, 7'd0,   20, 1'b0, 1'b1);
    vecs[14] = mk(1'b1, 1'b0, 1'b0, 2'd2, 7'd0,   40, 1'b0, 1'b1);
    vecs[15] = mk(1'b1, 1'b0, 1'b0, 2'd1, 7'd0,  200, 1'b0, 1'b1);

    for (int v = 0; v < NV; v++) begin
      for (int c = 0; c < vecs[v].cycles; c++) ciclo(vecs[v].r, vecs[v].s, vecs[v].p, vecs[v].nv, vecs[v].h);
      if (vecs[v].chk) check_const($sformatf("vec%0d", v), 28'h0, 1'b0, 8'd0, vecs[v].x_act);
      $display("vec %0d: rst_n=%b start=%b pausa=%b nivel=%0d cycles=%0d -> enemigos=%h puntos=%0d activo=%b",
               v, vecs[v].r, vecs[v].s, vecs[v].p, vecs[v].nv, vecs[v].cycles, enemigos, puntos, activo);
    end

    // Collision with an upper-set glyph, frozen display, restart
    ciclo(1'b0, 1'b0, 1'b0, 2'd2, 7'b1000000);
    ciclo(1'b1, 1'b1, 1'b0, 2'd2, 7'b1000000);
    hit_seen = 1'b0;
    for (int k = 0; k < 3000 && !hit_seen; k++) begin
      ciclo(1'b1, 1'b0, 1'b0, 2'd2, 7'b1000000);
      if (choque === 1'b1) hit_seen = 1'b1;
    end
    check("collision_seen", 32'(hit_seen), 32'd1);
    check("hit_glyph_upper", 32'(enemigos[6]), 32'd1);
    $display("seq collision: enemigos=%h puntos=%0d choque=%b", enemigos, puntos, choque);
    for (int k = 0; k < 100; k++) ciclo(1'b1, 1'b0, k[2], 2'(k), (k[3] ? 7'h7F : 7'd0));
    check("hit_hold_choque", 32'(choque), 32'd1);
    check("hit_hold_activo", 32'(activo), 32'd0);
    $display("seq frozen: enemigos=%h puntos=%0d choque=%b", enemigos, puntos, choque);
    ciclo(1'b1, 1'b1, 1'b0, 2'd3, 7'b1000000);
    check_const("restart", 28'h0, 1'b0, 8'd0, 1'b1);
    $display("seq restart: enemigos=%h puntos=%0d activo=%b", enemigos, puntos, activo);

    // Second collision, then reset while in HIT
    hit_seen = 1'b0;
    for (int k = 0; k < 3000 && !hit_seen; k++) begin
      ciclo(1'b1, 1'b0, 1'b0, 2'd3, 7'b1000000);
      if (choque === 1'b1) hit_seen = 1'b1;
    end
    check("collision2_seen", 32'(hit_seen), 32'd1);
    ciclo(1'b1, 1'b0, 1'b1, 2'd3, 7'b1000000);
    ciclo(1'b0, 1'b1, 1'b0, 2'd3, 7'b1000000);
    check_const("reset_in_hit", 28'h0, 1'b0, 8'd0, 1'b0);
    $display("seq reset_in_hit: enemigos=%h choque=%b activo=%b", enemigos, choque, activo);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
